// File: rtl/dds_pkg.sv
// Shared constants and sample-format helpers for the DDS voice path.
// Samples travel between blocks as offset binary; arithmetic is done in
// two's complement, so conversion is a flip of the MSB in either direction.
package dds_pkg;

  localparam int unsigned      DDS_M        = 12;
  localparam int unsigned      DDS_NV       = 4;
  localparam logic [DDS_M-1:0] DDS_MIDSCALE = 12'h800;

  function automatic logic signed [DDS_M-1:0] obin_to_s(input logic [DDS_M-1:0] v);
    return {~v[DDS_M-1], v[DDS_M-2:0]};
  endfunction

  function automatic logic [DDS_M-1:0] s_to_obin(input logic signed [DDS_M-1:0] v);
    return {~v[DDS_M-1], v[DDS_M-2:0]};
  endfunction

  // Clamp a sum of up to four M-bit voices (M+2 bits signed) to M bits signed.
  function automatic logic signed [DDS_M-1:0] sat_m(input logic signed [DDS_M+1:0] v);
    logic signed [DDS_M+1:0] hi;
    logic signed [DDS_M+1:0] lo;
    hi = {3'b000, {(DDS_M-1){1'b1}}};
    lo = {3'b111, {(DDS_M-1){1'b0}}};
    if (v > hi)      return {1'b0, {(DDS_M-1){1'b1}}};
    else if (v < lo) return {1'b1, {(DDS_M-1){1'b0}}};
    else             return v[DDS_M-1:0];
  endfunction

endpackage

// File: rtl/dds_sdm_dac.sv
// First-order sigma-delta modulator.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   din  - unsigned M-bit level (offset-binary sample)
//   dout - 1-bit stream whose ones density is din / 2^M
module dds_sdm_dac
  import dds_pkg::*;
#(
  parameter int unsigned M = DDS_M
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [M-1:0] din,
  output logic         dout
);

  logic [M-1:0] r_sacc;
  logic         r_dout;
  logic [M:0]   w_nxt;

  // Carry out of the M-bit accumulator is the output bit.
  assign w_nxt = {1'b0, r_sacc} + {1'b0, din};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sacc <= '0;
      r_dout <= 1'b0;
    end else begin
      r_sacc <= w_nxt[M-1:0];
      r_dout <= w_nxt[M];
    end
  end

  assign dout = r_dout;

endmodule

// File: rtl/dds_voice_mixer.sv
// Voice mixer for the 4-voice DDS core.
// Each frame (NV+1 clocks) the voice samples, enables and attenuations are
// snapshotted, the voices are summed one per clock, and the saturated mix is
// registered as offset binary and fed to a sigma-delta DAC.
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-high reset
//   voices_i   - NV packed offset-binary samples, voice k = [k*M +: M]
//   voice_en_i - per-voice enable (disabled voice contributes midscale)
//   atten_i    - per-voice arithmetic right shift, voice k = [k*AW +: AW]
//   mix_o      - registered mix, offset binary
//   mix_vld_o  - one-cycle pulse when mix_o updates
//   sdm_o      - sigma-delta bitstream of mix_o
module dds_voice_mixer
  import dds_pkg::*;
#(
  parameter int unsigned M  = DDS_M,
  parameter int unsigned NV = DDS_NV,
  parameter int unsigned AW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NV*M-1:0] voices_i,
  input  logic [NV-1:0]   voice_en_i,
  input  logic [NV*AW-1:0] atten_i,
  output logic [M-1:0]    mix_o,
  output logic            mix_vld_o,
  output logic            sdm_o
);

  localparam int unsigned IW  = (NV > 1) ? $clog2(NV) : 1;
  localparam int unsigned PW  = $clog2(NV + 1);
  localparam int unsigned AAW = M + $clog2(NV);

  localparam logic signed [AAW-1:0] SMAX = {{(AAW-M+1){1'b0}}, {(M-1){1'b1}}};
  localparam logic signed [AAW-1:0] SMIN = {{(AAW-M+1){1'b1}}, {(M-1){1'b0}}};

  logic [PW-1:0]          r_phase;
  logic [NV*M-1:0]        r_voices;
  logic [NV-1:0]          r_en;
  logic [NV*AW-1:0]       r_atten;
  logic signed [AAW-1:0]  r_acc;
  logic [M-1:0]           r_mix;
  logic                   r_vld;

  logic [IW-1:0]          w_idx;
  logic [M-1:0]           w_sel_v;
  logic                   w_sel_en;
  logic [AW-1:0]          w_sel_at;
  logic signed [M-1:0]    w_s;
  logic signed [M-1:0]    w_sh;
  logic signed [AAW-1:0]  w_term;
  logic signed [AAW-1:0]  w_sum;
  logic signed [M-1:0]    w_sat;
  logic [M-1:0]           w_mix;

  // At phase k (1..NV) the term for voice k-1 is added.
  assign w_idx = IW'(r_phase - PW'(1));

  always_comb begin
    w_sel_v  = r_voices[w_idx*M +: M];
    w_sel_en = r_en[w_idx];
    w_sel_at = r_atten[w_idx*AW +: AW];
    w_s      = {~w_sel_v[M-1], w_sel_v[M-2:0]};
    w_sh     = w_s >>> w_sel_at;
    w_term   = w_sel_en ? {{(AAW-M){w_sh[M-1]}}, w_sh} : '0;
    w_sum    = r_acc + w_term;
    if (w_sum > SMAX)      w_sat = {1'b0, {(M-1){1'b1}}};
    else if (w_sum < SMIN) w_sat = {1'b1, {(M-1){1'b0}}};
    else                   w_sat = w_sum[M-1:0];
    w_mix    = {~w_sat[M-1], w_sat[M-2:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase  <= '0;
      r_voices <= '0;
      r_en     <= '0;
      r_atten  <= '0;
      r_acc    <= '0;
      r_mix    <= {1'b1, {(M-1){1'b0}}};
      r_vld    <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      if (r_phase == '0) begin
        r_voices <= voices_i;
        r_en     <= voice_en_i;
        r_atten  <= atten_i;
        r_acc    <= '0;
        r_phase  <= PW'(1);
      end else if (r_phase == PW'(NV)) begin
        // Last voice goes straight into the output; the accumulator is left alone.
        r_mix   <= w_mix;
        r_vld   <= 1'b1;
        r_phase <= '0;
      end else begin
        r_acc   <= w_sum;
        r_phase <= r_phase + PW'(1);
      end
    end
  end

  assign mix_o     = r_mix;
  assign mix_vld_o = r_vld;

  dds_sdm_dac #(
    .M (M)
  ) u_sdm (
    .clk  (clk),
    .rst  (rst),
    .din  (r_mix),
    .dout (sdm_o)
  );

endmodule

// File: tb/tb_dds_voice_mixer.sv
module tb_dds_voice_mixer;

  logic        clk;
  logic        rst;
  logic [47:0] voices_i;
  logic [3:0]  voice_en_i;
  logic [7:0]  atten_i;
  logic [11:0] mix_o;
  logic        mix_vld_o;
  logic        sdm_o;

  int n_vec;
  int n_err;

  dds_voice_mixer #(
    .M  (12),
    .NV (4),
    .AW (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .voices_i   (voices_i),
    .voice_en_i (voice_en_i),
    .atten_i    (atten_i),
    .mix_o      (mix_o),
    .mix_vld_o  (mix_vld_o),
    .sdm_o      (sdm_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns at the negedge where mix_vld_o is seen high.
  task automatic wait_vld(input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mix_vld_o) return;
    end
    check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic apply(input logic [47:0] v, input logic [3:0] en, input logic [7:0] at);
    voices_i   = v;
    voice_en_i = en;
    atten_i    = at;
  endtask

  task automatic run_case(input string tag, input logic [47:0] v, input logic [3:0] en,
                          input logic [7:0] at, input logic [11:0] exp);
    apply(v, en, at);
    wait_vld(tag);
    wait_vld(tag);
    check(tag, {20'd0, mix_o}, {20'd0, exp});
  endtask

  task automatic cycles_to_vld(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (mix_vld_o) return;
    end
  endtask

  task automatic count_ones(input int len, output int ones);
    ones = 0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (sdm_o) ones++;
    end
  endtask

  initial begin
    int n;
    int ones;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    apply({4{12'h800}}, 4'hF, 8'h00);

    repeat (3) @(negedge clk);
    check("rst_mix", {20'd0, mix_o}, 32'h800);
    check("rst_vld", {31'd0, mix_vld_o}, 32'd0);
    check("rst_sdm", {31'd0, sdm_o}, 32'd0);

    rst = 1'b0;
    cycles_to_vld(n);
    check("first_pulse", n, 32'd5);
    check("midscale", {20'd0, mix_o}, 32'h800);
    wait_vld("mid2");
    check("midscale2", {20'd0, mix_o}, 32'h800);
    count_ones(4096, ones);
    check("sdm_800", ones, 32'd2048);

    run_case("v0_full",  {12'h800, 12'h800, 12'h800, 12'hFFF}, 4'hF, 8'h00, 12'hFFF);
    run_case("v0_att3",  {12'h800, 12'h800, 12'h800, 12'hFFF}, 4'hF, 8'h03, 12'h8FF);
    run_case("v0_neg1",  {12'h800, 12'h800, 12'h800, 12'h000}, 4'hF, 8'h01, 12'h400);
    run_case("sat_pos",  {4{12'hFFF}}, 4'hF, 8'h00, 12'hFFF);
    run_case("sat_neg",  {4{12'h000}}, 4'hF, 8'h00, 12'h000);
    run_case("en_0001",  {4{12'hFFF}}, 4'b0001, 8'h00, 12'hFFF);
    run_case("en_none",  {12'h123, 12'h000, 12'hFFF, 12'h456}, 4'b0000, 8'h00, 12'h800);
    // 512 - 256 + (256>>>2) + 0 = 320 -> 0x940
    run_case("mixed",    {12'h800, 12'h900, 12'h700, 12'hA00}, 4'hF, 8'b00_10_00_00, 12'h940);
    // -1 >>> 3 stays -1
    run_case("neg_shift", {12'h800, 12'h800, 12'h800, 12'h7FF}, 4'hF, 8'h03, 12'h7FF);
    run_case("en_v3",    {12'h000, 12'hFFF, 12'hFFF, 12'hFFF}, 4'b1000, 8'h00, 12'h000);

    cycles_to_vld(n);
    check("period", n, 32'd5);

    // Snapshot: change inputs just after the phase-0 edge.
    run_case("snap_pre", {12'h800, 12'h800, 12'h800, 12'hFFF}, 4'hF, 8'h00, 12'hFFF);
    wait_vld("snap_sync");
    @(posedge clk);
    #1 apply({4{12'h000}}, 4'hF, 8'h00);
    wait_vld("snap_old");
    check("snap_old", {20'd0, mix_o}, 32'hFFF);
    wait_vld("snap_new");
    check("snap_new", {20'd0, mix_o}, 32'h000);

    // Reset mid-frame at phase 2.
    run_case("rst_pre", {12'h800, 12'h800, 12'h800, 12'hFFF}, 4'hF, 8'h00, 12'hFFF);
    wait_vld("rst_sync");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_mix", {20'd0, mix_o}, 32'h800);
    check("midrst_vld", {31'd0, mix_vld_o}, 32'd0);
    check("midrst_sdm", {31'd0, sdm_o}, 32'd0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (mix_vld_o) n++;
    end
    check("midrst_nopulse", n, 32'd0);
    rst = 1'b0;
    cycles_to_vld(n);
    check("rst_first_pulse", n, 32'd5);
    check("rst_first_mix", {20'd0, mix_o}, 32'hFFF);

    // SDM densities.
    run_case("c00", {12'h800, 12'h800, 12'h800, 12'hC00}, 4'hF, 8'h00, 12'hC00);
    count_ones(4096, ones);
    check("sdm_c00", ones, 32'd3072);
    run_case("zero", {4{12'h000}}, 4'hF, 8'h00, 12'h000);
    repeat (2) @(negedge clk);
    count_ones(64, ones);
    check("sdm_000", ones, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
